// File: rtl/boot_mode_ctrl.sv
// Boot-mode sequencer: debounces the program/run buttons, owns the UART
// programmer and CPU resets, steers programmer writes and times out stalled loads.
module boot_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int DB_W            = 18,
    parameter int TIMEOUT_CYCLES  = 50000000,
    parameter int TO_W            = 26,
    parameter int HOLD_CYCLES     = 16,
    parameter int CNT_W           = 16
) (
    input  logic             fpga_clk,
    input  logic             fpga_rst,
    input  logic             upg_btn,
    input  logic             run_btn,
    input  logic             upg_wen_i,
    input  logic [14:0]      upg_adr_i,
    input  logic             upg_done_i,
    output logic             upg_rst_o,
    output logic             cpu_rst_o,
    output logic             imem_wen_o,
    output logic             dmem_wen_o,
    output logic [13:0]      mem_adr_o,
    output logic [CNT_W-1:0] word_cnt_o,
    output logic [1:0]       mode_o,
    output logic             timeout_o
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RUN  = 3'd0,
        ST_ARM  = 3'd1,
        ST_LOAD = 3'd2,
        ST_HOLD = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    // Button index 0 is upg_btn, index 1 is run_btn.
    logic [1:0]      sync1_q, sync2_q, filt_q, filt_d, press;
    logic [DB_W-1:0] dbcnt_q [2];
    logic [DB_W-1:0] dbcnt_d [2];

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              loading, accept;

    always_ff @(posedge fpga_clk or posedge fpga_rst) begin
        if (fpga_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            for (int i = 0; i < 2; i++) dbcnt_q[i] <= '0;
            state_q <= ST_HOLD;
            hold_q  <= '0;
            to_q    <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= {run_btn, upg_btn};
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            for (int i = 0; i < 2; i++) dbcnt_q[i] <= dbcnt_d[i];
            state_q <= state_d;
            hold_q  <= hold_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    // The filtered level only flips once the synchronised input has disagreed
    // with it for DEBOUNCE_CYCLES samples in a row; the press pulse rides that flip.
    always_comb begin
        filt_d = filt_q;
        press  = '0;
        for (int i = 0; i < 2; i++) begin
            dbcnt_d[i] = dbcnt_q[i];
            if (sync2_q[i] == filt_q[i]) begin
                dbcnt_d[i] = '0;
            end else if (dbcnt_q[i] == DB_LAST) begin
                dbcnt_d[i] = '0;
                filt_d[i]  = sync2_q[i];
                press[i]   = sync2_q[i];
            end else begin
                dbcnt_d[i] = dbcnt_q[i] + DB_W'(1);
            end
        end
    end

    assign loading = (state_q == ST_ARM) || (state_q == ST_LOAD);
    assign accept  = loading && upg_wen_i;

    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        to_d    = '0;
        cnt_d   = cnt_q;
        if (accept && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
        unique case (state_q)
            ST_RUN: begin
                if (press[0]) begin
                    state_d = ST_ARM;
                    cnt_d   = '0;
                end
            end
            ST_ARM: begin
                to_d = to_q + TO_W'(1);
                if (upg_done_i || press[1]) begin
                    state_d = ST_HOLD;
                end else if (upg_wen_i) begin
                    state_d = ST_LOAD;
                    to_d    = '0;
                end else if (to_q == TO_LAST) begin
                    state_d = ST_ERR;
                end
            end
            ST_LOAD: begin
                to_d = upg_wen_i ? '0 : to_q + TO_W'(1);
                if (upg_done_i || press[1]) begin
                    state_d = ST_HOLD;
                end else if (!upg_wen_i && (to_q == TO_LAST)) begin
                    state_d = ST_ERR;
                end
            end
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) state_d = ST_RUN;
                else                     hold_d  = hold_q + HOLD_W'(1);
            end
            ST_ERR: begin
                // A simultaneous upg press takes priority over run.
                if (press[0]) begin
                    state_d = ST_ARM;
                    cnt_d   = '0;
                end else if (press[1]) begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    always_comb begin
        mode_o = 2'd2;
        unique case (state_q)
            ST_RUN:          mode_o = 2'd0;
            ST_ARM, ST_LOAD: mode_o = 2'd1;
            ST_HOLD:         mode_o = 2'd2;
            ST_ERR:          mode_o = 2'd3;
            default:         mode_o = 2'd2;
        endcase
    end

    assign upg_rst_o  = !loading;
    assign cpu_rst_o  = (state_q != ST_RUN);
    assign timeout_o  = (state_q == ST_ERR);
    assign imem_wen_o = accept && !upg_adr_i[14];
    assign dmem_wen_o = accept && upg_adr_i[14];
    assign mem_adr_o  = upg_adr_i[13:0];
    assign word_cnt_o = cnt_q;

endmodule
